// File: rtl/ro_sampler_packer_pkg.sv
// Shared TRNG parameter defaults and the von Neumann pair-state type.
// Used by ro_sampler_packer and vn_debias.
package ro_sampler_packer_pkg;

    localparam int WORD_W_DEF      = 32;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int SAMPLE_DIV_DEF  = 4;
    localparam int RCT_CUTOFF_DEF  = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } vn_state_t;

endpackage

// File: rtl/ro_sampler_packer_vn_debias.sv
// Von Neumann corrector: pairs successive strobed samples, emits the first bit of
// each unequal pair and discards equal pairs. clr returns the pair state to EMPTY.
module vn_debias
    import ro_sampler_packer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic stb,
    input  logic in_bit,
    output logic out_stb,
    output logic out_bit
);

    vn_state_t state_q, state_nxt;
    logic      first_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= EMPTY;
            first_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (stb && !clr && state_q == EMPTY) first_q <= in_bit;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        state_nxt = state_q;
        out_stb   = 1'b0;
        out_bit   = first_q;
        if (clr) begin
            state_nxt = EMPTY;
        end else if (stb) begin
            case (state_q)
                EMPTY: state_nxt = HELD;
                HELD: begin
                    state_nxt = EMPTY;
                    out_stb   = (first_q != in_bit);
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/ro_sampler_packer.sv
// Ring-oscillator bit sampler: synchronizer, sample divider, von Neumann corrector
// and word packer with a valid/ready output. Optional health test: TRNG_HEALTH_EN.
module ro_sampler_packer
    import ro_sampler_packer_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int SAMPLE_DIV  = SAMPLE_DIV_DEF,
    parameter int RCT_CUTOFF  = RCT_CUTOFF_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              raw_bit,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              health_fail
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    if (WORD_W < 2 || WORD_W > 64 || SYNC_STAGES < 2 || SAMPLE_DIV < 1 || RCT_CUTOFF < 1) begin : g_bad_param
        $error("ro_sampler_packer: parameter out of range");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic [DIV_W-1:0]       div_q;
    logic                   sample_stb;
    logic                   vn_stb, vn_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_bit};
    end
    assign sync_bit = sync_q[SYNC_STAGES-1];

    assign sample_stb = en && (div_q == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 div_q <= '0;
        else if (!en || sample_stb) div_q <= '0;
        else                        div_q <= div_q + DIV_W'(1);
    end

    vn_debias u_vn_debias (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!en),
        .stb    (sample_stb),
        .in_bit (sync_bit),
        .out_stb(vn_stb),
        .out_bit(vn_bit)
    );

`ifdef TRNG_HEALTH_EN
    localparam int RUN_W = $clog2(RCT_CUTOFF + 1);

    logic [RUN_W-1:0] run_q, run_nxt;
    logic             prev_q, health_q;

    // A zero run length marks "no previous sample yet", so the first sample starts a run of 1.
    always_comb begin
        run_nxt = run_q;
        if (run_q == '0 || sync_bit != prev_q) run_nxt = RUN_W'(1);
        else if (run_q != RUN_W'(RCT_CUTOFF))  run_nxt = run_q + RUN_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= '0;
            prev_q   <= 1'b0;
            health_q <= 1'b0;
        end else if (sample_stb) begin
            run_q  <= run_nxt;
            prev_q <= sync_bit;
            if (run_nxt == RUN_W'(RCT_CUTOFF)) health_q <= 1'b1;
        end
    end
    assign health_fail = health_q;
`else
    assign health_fail = 1'b0;
`endif

    logic [WORD_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              bit_in, out_free, word_full, load_full, load_fast;

    assign bit_in    = vn_stb && !health_fail;
    assign out_free  = !out_valid || out_ready;
    assign word_full = (cnt_q == CNT_W'(WORD_W));
    assign load_full = word_full && out_free && !health_fail;
    // The last bit of a word bypasses the shift register so the word appears one cycle after its strobe.
    assign load_fast = (cnt_q == CNT_W'(WORD_W - 1)) && bit_in && out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (!en) begin
                cnt_q <= '0;
            end else if (load_full) begin
                out_data  <= shift_q;
                out_valid <= 1'b1;
                if (bit_in) begin
                    shift_q <= {{(WORD_W-1){1'b0}}, vn_bit};
                    cnt_q   <= CNT_W'(1);
                end else begin
                    cnt_q <= '0;
                end
            end else if (load_fast) begin
                out_data  <= {shift_q[WORD_W-2:0], vn_bit};
                out_valid <= 1'b1;
                cnt_q     <= '0;
            end else if (bit_in) begin
                if (word_full) begin
                    overrun <= 1'b1;
                end else begin
                    shift_q <= {shift_q[WORD_W-2:0], vn_bit};
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ro_sampler_packer.sv
// Self-checking bench for ro_sampler_packer: random corrected bits against a
// sample-level model of pairing, packing, backpressure and the health test.
module tb_ro_sampler_packer;

    localparam int W      = 8;
    localparam int SYNC   = 2;
    localparam int CUTOFF = 32;
`ifdef TRNG_HEALTH_EN
    localparam bit HEALTH_ON = 1'b1;
`else
    localparam bit HEALTH_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, en, raw_bit, out_ready;
    logic [W-1:0] out_data;
    logic         out_valid, overrun, health_fail;
    logic         en4, raw4, ready4;
    logic [W-1:0] data4;
    logic         valid4, ovr4, hf4;

    ro_sampler_packer #(.WORD_W(W), .SYNC_STAGES(SYNC), .SAMPLE_DIV(1), .RCT_CUTOFF(CUTOFF)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .raw_bit(raw_bit),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .health_fail(health_fail)
    );

    ro_sampler_packer #(.WORD_W(W), .SYNC_STAGES(SYNC), .SAMPLE_DIV(4), .RCT_CUTOFF(CUTOFF)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .raw_bit(raw4),
        .out_data(data4), .out_valid(valid4), .out_ready(ready4),
        .overrun(ovr4), .health_fail(hf4)
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    int           valid_cycles;
    logic [W-1:0] got[$];
    logic [W-1:0] got4[$];
    bit           tag_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge after inputs are set; records what the next posedge accepts.
    task automatic tick();
        if (out_valid && out_ready) got.push_back(out_data);
        if (out_valid) valid_cycles++;
        if (valid4 && ready4) got4.push_back(data4);
        @(negedge clk);
    endtask

    // Each sample carries the enable it should see when it reaches the synchronizer output.
    task automatic push(input logic b, input bit tag);
        raw_bit = b;
        tag_q.push_back(tag);
        en = (tag_q.size() > SYNC) ? tag_q[tag_q.size() - 1 - SYNC] : 1'b0;
        tick();
    endtask

    task automatic push_pair(input logic a, input logic b);
        push(a, 1'b1);
        push(b, 1'b1);
    endtask

    task automatic push_bit(input logic b);
        push_pair(b, !b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) push_pair(i[0], i[0]);
    endtask

    function automatic logic [W-1:0] pack(input bit q[$], input int base);
        logic [W-1:0] w = '0;
        for (int i = 0; i < W; i++) w = {w[W-2:0], q[base + i]};
        return w;
    endfunction

    function automatic logic [W-1:0] got_at(input int i);
        return (got.size() > i) ? got[i] : 'x;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; en4 = 1'b0; out_ready = 1'b0; ready4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            raw_bit = 1'($urandom); raw4 = 1'($urandom);
            @(negedge clk);
        end
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, '0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_health", health_fail, 1'b0);
        rst_n = 1'b1;
        tag_q.delete(); got.delete(); got4.delete();
        valid_cycles = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit           bits[$];
        bit           bits_b[$];
        bit           v[$];
        logic [1:0]   pairs[10];
        logic [W-1:0] w1, w2;
        bit           b;
        int           idx;

        // Correction: fixed pair table with ready held high.
        do_reset();
        out_ready = 1'b1;
        pairs = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b10, 2'b01};
        bits.delete();
        foreach (pairs[i]) begin
            if (pairs[i][1] != pairs[i][0]) bits.push_back(pairs[i][1]);
            push_pair(pairs[i][1], pairs[i][0]);
        end
        check("corr_bits", bits.size(), W);
        check("corr_before_strobe", out_valid, 1'b0);
        push_pair(1'b0, 1'b0);
        check("corr_latency", out_valid, 1'b1);
        idle(4);
        check("corr_words", got.size(), 1);
        check("corr_data", got_at(0), pack(bits, 0));
        check("corr_valid_cycles", valid_cycles, 1);

        // Backpressure: 24 corrected bits with ready low, equal pairs sprinkled in.
        do_reset();
        bits.delete();
        for (int i = 0; i < 3 * W; i++) begin
            b = 1'($urandom);
            bits.push_back(b);
            push_bit(b);
            if ($urandom_range(2) == 0) begin
                b = 1'($urandom);
                push_pair(b, b);
            end
            if (i == 2 * W - 1) begin
                idle(1);
                check("bp_valid_held", out_valid, 1'b1);
                check("bp_word1_stable_a", out_data, pack(bits, 0));
                check("bp_no_overrun_yet", overrun, 1'b0);
            end
        end
        idle(1);
        check("bp_word1_stable_b", out_data, pack(bits, 0));
        check("bp_overrun", overrun, 1'b1);
        check("bp_none_accepted", got.size(), 0);
        out_ready = 1'b1;
        idle(4);
        check("bp_words", got.size(), 2);
        check("bp_word1", got_at(0), pack(bits, 0));
        check("bp_word2", got_at(1), pack(bits, W));
        check("bp_overrun_sticky", overrun, 1'b1);

        // Mid-operation reset drops a held word without waiting for a clock edge.
        out_ready = 1'b0;
        for (int i = 0; i < W; i++) push_bit(1'($urandom));
        idle(1);
        check("mr_valid_before", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_valid_async", out_valid, 1'b0);
        check("mr_overrun_async", overrun, 1'b0);

        // Enable abort: partial word discarded, next word holds only post-enable bits.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_bit(1'($urandom));
        for (int i = 0; i < 3; i++) push(1'($urandom), 1'b0);
        bits.delete();
        for (int i = 0; i < W; i++) begin
            b = 1'($urandom);
            bits.push_back(b);
            push_bit(b);
        end
        idle(3);
        check("ena_words", got.size(), 1);
        check("ena_data", got_at(0), pack(bits, 0));

        // Divider A: toggling raw bit sampled every 4th clock gives only equal pairs.
        do_reset();
        for (int t = 0; t < 120; t++) begin
            raw4 = t[0];
            en4  = (t >= 4);
            tick();
        end
        check("div_toggle_no_words", got4.size(), 0);

        // Divider B: raw held constant over 4-clock blocks, one corrected bit per block pair.
        do_reset();
        bits_b.delete(); v.delete();
        for (int i = 0; i < W; i++) begin
            b = 1'($urandom);
            bits_b.push_back(b);
            v.push_back(b);
            v.push_back(!b);
        end
        v.push_back(1'b0); v.push_back(1'b0);
        for (int t = 0; t < 4 + 1 + 4 * v.size() + 12; t++) begin
            en4 = (t >= 4);
            idx = t - 5;
            raw4 = (idx >= 0 && idx / 4 < v.size()) ? v[idx / 4] : 1'b0;
            tick();
        end
        check("div_words", got4.size(), 1);
        check("div_data", (got4.size() > 0) ? got4[0] : 'x, pack(bits_b, 0));
        check("div_no_overrun", ovr4, 1'b0);

        // Health: a run of 30 must not trip; a run of 32 trips only with the test built in.
        do_reset();
        out_ready = 1'b1;
        push_pair(1'b0, 1'b0);
        for (int i = 0; i < (CUTOFF - 2) / 2; i++) push_pair(1'b1, 1'b1);
        push_pair(1'b0, 1'b0);
        check("hlt_run30", health_fail, 1'b0);
        for (int i = 0; i < CUTOFF / 2; i++) push_pair(1'b1, 1'b1);
        push_pair(1'b0, 1'b0);
        check("hlt_run32", health_fail, HEALTH_ON);
        bits.delete();
        for (int i = 0; i < W; i++) begin
            b = 1'($urandom);
            bits.push_back(b);
            push_bit(b);
        end
        idle(3);
        check("hlt_words", got.size(), HEALTH_ON ? 0 : 1);
        if (!HEALTH_ON) check("hlt_data", got_at(0), pack(bits, 0));
        check("hlt_no_overrun", overrun, 1'b0);
        check("hlt_sticky", health_fail, HEALTH_ON);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
